// File: rtl/uart_tx_sched.sv
// Round-robin TX scheduler driving the MiniUART WISHBONE slave: programs DIVR/DIVT after reset,
// polls LSR.ts, then writes DATA. Optional poll timeout is enabled by `define UART_SCHED_TIMEOUT_EN.
module uart_tx_sched #(
  parameter int          NREQ        = 2,
  parameter logic [2:0]  ADDR_DATA   = 3'd0,
  parameter logic [2:0]  ADDR_LSR    = 3'd1,
  parameter logic [2:0]  ADDR_DIVR   = 3'd2,
  parameter logic [2:0]  ADDR_DIVT   = 3'd3,
  parameter logic [15:0] DIVR_INIT   = 16'd325,
  parameter logic [15:0] DIVT_INIT   = 16'd5207,
  parameter int          HOLD_CYC    = 3,
  parameter logic [15:0] TIMEOUT_CYC = 16'd60000
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [2:0]        ADD_O,
  output logic [31:0]       DAT_O,
  output logic              STB_O,
  output logic              WE_O,
  input  logic              ACK_I,
  input  logic [31:0]       DAT_I,
  output logic [2:0]        grant_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_INIT_R, S_INIT_T, S_IDLE, S_POLL, S_WRITE, S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  grant_q, grant_d;
  logic [7:0]  byte_q, byte_d;
  logic [3:0]  hold_q, hold_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [2:0]  add_q, add_d;
  logic [31:0] dat_q, dat_d;
  logic        busy_q, busy_d;

  logic            ack;
  logic            arb_found;
  logic [2:0]      arb_idx;
  logic [7:0]      arb_byte;
  logic [NREQ-1:0] rot_valid;
  int              arb_off;
  int              arb_sum;

  // Bus outputs are registered from the state being entered, so they line up with state_q.
  assign ack = ACK_I & stb_q;

  // Rotate valids so bit 0 is the requester just after the pointer; the lowest set bit wins.
  always_comb begin
    // NOTE: every combinational output gets a default first; otherwise paths that skip an assignment infer latches.
    arb_found = 1'b0;
    arb_off   = 0;
    rot_valid = NREQ'({req_valid, req_valid} >> ({1'b0, ptr_q} + 4'd1));
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot_valid[i]) begin
        arb_found = 1'b1;
        arb_off   = i;
      end
    end
    arb_sum = int'(ptr_q) + 1 + arb_off;
    if (arb_sum >= NREQ) arb_sum = arb_sum - NREQ;
    arb_idx  = 3'(arb_sum);
    arb_byte = 8'(req_data >> {arb_idx, 3'b000});
  end

`ifdef UART_SCHED_TIMEOUT_EN
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    byte_d    = byte_q;
    hold_d    = hold_q;
    req_ready = '0;
`ifdef UART_SCHED_TIMEOUT_EN
    poll_cnt_d = poll_cnt_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      S_INIT_R: if (ack) state_d = S_INIT_T;
      S_INIT_T: if (ack) state_d = S_IDLE;
      S_IDLE: begin
        if (arb_found) begin
          req_ready = {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
          byte_d    = arb_byte;
          grant_d   = arb_idx;
          ptr_d     = arb_idx;
          state_d   = S_POLL;
`ifdef UART_SCHED_TIMEOUT_EN
          poll_cnt_d = '0;
`endif
        end
      end
      S_POLL: begin
        if (ack && DAT_I[5]) begin
          state_d = S_WRITE;
        end
`ifdef UART_SCHED_TIMEOUT_EN
        else if (ack) begin
          // The pointer already moved at grant time, so a dropped byte still rotates priority.
          if (poll_cnt_q == TIMEOUT_CYC - 16'd1) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            poll_cnt_d = poll_cnt_q + 16'd1;
          end
        end
`endif
      end
      S_WRITE: begin
        if (ack) begin
          hold_d  = 4'(HOLD_CYC);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        hold_d = hold_q - 4'd1;
        if (hold_q == 4'd1) state_d = S_IDLE;
      end
      default: state_d = S_INIT_R;
    endcase

    stb_d  = 1'b0;
    we_d   = 1'b0;
    add_d  = add_q;
    dat_d  = '0;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_INIT_R: begin stb_d = 1'b1; we_d = 1'b1; add_d = ADDR_DIVR; dat_d = {16'b0, DIVR_INIT}; end
      S_INIT_T: begin stb_d = 1'b1; we_d = 1'b1; add_d = ADDR_DIVT; dat_d = {16'b0, DIVT_INIT}; end
      S_POLL:   begin stb_d = 1'b1; add_d = ADDR_LSR; end
      S_WRITE:  begin stb_d = 1'b1; we_d = 1'b1; add_d = ADDR_DATA; dat_d = {24'b0, byte_d}; end
      default:  ;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (RST_I) begin
      state_q <= S_INIT_R;
      ptr_q   <= 3'(NREQ - 1);
      grant_q <= '0;
      byte_q  <= '0;
      hold_q  <= '0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      add_q   <= '0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      byte_q  <= byte_d;
      hold_q  <= hold_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      add_q   <= add_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_SCHED_TIMEOUT_EN
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      poll_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;

  logic unused_ok;
  assign unused_ok = ^{DAT_I[31:6], DAT_I[4:0]};
`else
  assign err_o = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{DAT_I[31:6], DAT_I[4:0], TIMEOUT_CYC};
`endif

  assign STB_O   = stb_q;
  assign WE_O    = we_q;
  assign ADD_O   = add_q;
  assign DAT_O   = dat_q;
  assign grant_o = grant_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: stimulus queues expected bus transactions, a monitor
// pops and compares each acknowledged UART access; a small LSR model controls ts.
module tb_uart_tx_sched;

  localparam int NREQ = 2;

  typedef struct packed {
    logic        we;
    logic [2:0]  add;
    logic [31:0] dat;
    logic [2:0]  grant;
  } txn_t;

  logic              CLK_I = 1'b0;
  logic              RST_I;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [2:0]        ADD_O;
  logic [31:0]       DAT_O;
  logic              STB_O;
  logic              WE_O;
  logic              ACK_I;
  logic [31:0]       DAT_I;
  logic [2:0]        grant_o;
  logic              busy_o;
  logic              err_o;

  logic ack_en;
  int   lsr_reads = 0;
  int   lsr_limit = 0;
  logic lsr_ts;

  int   n_checks = 0;
  int   n_fail   = 0;
  txn_t sb[$];

  uart_tx_sched #(.NREQ(NREQ), .TIMEOUT_CYC(16'd8)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .ADD_O(ADD_O), .DAT_O(DAT_O), .STB_O(STB_O), .WE_O(WE_O),
    .ACK_I(ACK_I), .DAT_I(DAT_I),
    .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 CLK_I = ~CLK_I;

  // UART slave model: acks every strobe unless stalled; ts stays low until lsr_limit reads happened.
  assign ACK_I  = STB_O & ack_en;
  assign lsr_ts = (lsr_reads >= lsr_limit);
  assign DAT_I  = {26'b0, lsr_ts, 5'b0};

  always @(posedge CLK_I)
    if (STB_O && ACK_I && !WE_O && ADD_O == 3'd1) lsr_reads <= lsr_reads + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_rd();
    sb.push_back('{we: 1'b0, add: 3'd1, dat: 32'd0, grant: 3'd0});
  endtask

  task automatic push_wr(input logic [2:0] add, input logic [31:0] dat, input logic [2:0] g);
    sb.push_back('{we: 1'b1, add: add, dat: dat, grant: g});
  endtask

  // Monitor: every acknowledged strobe is one UART access.
  always @(negedge CLK_I) begin
    if (STB_O && ACK_I) begin
      txn_t act, exp;
      act.we    = WE_O;
      act.add   = ADD_O;
      act.dat   = DAT_O;
      act.grant = (WE_O && ADD_O == 3'd0) ? grant_o : 3'd0;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_txn: got 0x%0h, want no access (t=%0t)", act, $time);
      end else begin
        exp = sb.pop_front();
        check("bus_txn", 64'(act), 64'(exp));
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge CLK_I);
    while (busy_o && n < budget) begin
      @(negedge CLK_I);
      n++;
    end
    check("idle_reached", 64'(busy_o), 64'd0);
  endtask

  // Waits for a grant, checks the one-hot accept, and returns just after the accepting edge.
  task automatic wait_grant(input logic [NREQ-1:0] exp_ready, input int budget);
    int n = 0;
    #1;
    while (req_ready == '0 && n < budget) begin
      @(negedge CLK_I);
      n++;
    end
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    @(posedge CLK_I);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST_I     = 1'b1;
    req_valid = 2'b11;
    req_data  = 16'h0000;
    ack_en    = 1'b1;

    // Reset state, with requests pending to show req_ready stays low.
    repeat (3) @(posedge CLK_I);
    @(negedge CLK_I);
    check("rst_stb", 64'(STB_O), 64'd0);
    check("rst_we", 64'(WE_O), 64'd0);
    check("rst_add", 64'(ADD_O), 64'd0);
    check("rst_dat", 64'(DAT_O), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_grant", 64'(grant_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    req_valid = 2'b00;

    // Divisor programming in cycles 1 and 2 after release.
    push_wr(3'd2, 32'd325, 3'd0);
    push_wr(3'd3, 32'd5207, 3'd0);
    RST_I = 1'b0;
    @(negedge CLK_I);
    check("init_r_add", 64'({STB_O, WE_O, ADD_O}), 64'({1'b1, 1'b1, 3'd2}));
    @(negedge CLK_I);
    check("init_t_add", 64'({STB_O, WE_O, ADD_O}), 64'({1'b1, 1'b1, 3'd3}));
    @(negedge CLK_I);
    check("idle_busy", 64'(busy_o), 64'd0);
    check("idle_stb", 64'(STB_O), 64'd0);
    check("idle_add_held", 64'(ADD_O), 64'd3);

    // Single byte, transmitter idle: exact cycle-by-cycle sequence.
    req_data  = 16'h0041;
    req_valid = 2'b01;
    push_rd();
    push_wr(3'd0, 32'h41, 3'd0);
    #1;
    check("t2_ready", 64'(req_ready), 64'b01);
    @(posedge CLK_I);
    #1;
    req_valid = 2'b00;
    @(negedge CLK_I);
    check("t2_poll", 64'({STB_O, WE_O, ADD_O, busy_o}), 64'({1'b1, 1'b0, 3'd1, 1'b1}));
    check("t2_grant", 64'(grant_o), 64'd0);
    @(negedge CLK_I);
    check("t2_write", 64'({STB_O, WE_O, ADD_O, DAT_O}), 64'({1'b1, 1'b1, 3'd0, 32'h41}));
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK_I);
      check("t2_hold", 64'({STB_O, WE_O, DAT_O, busy_o}), 64'({1'b0, 1'b0, 32'd0, 1'b1}));
    end
    @(negedge CLK_I);
    check("t2_idle", 64'(busy_o), 64'd0);
    check("t2_add_held", 64'(ADD_O), 64'd0);

    // Transmitter busy for 10 polls; a requester raising and dropping valid meanwhile is ignored.
    lsr_limit = lsr_reads + 10;
    req_data  = 16'h7700;
    req_valid = 2'b10;
    for (int i = 0; i < 11; i++) push_rd();
    push_wr(3'd0, 32'h77, 3'd1);
    wait_grant(2'b10, 10);
    req_data  = 16'h77EE;
    req_valid = 2'b01;
    begin
      int n = 0;
      @(negedge CLK_I);
      while (!(STB_O && WE_O) && n < 40) begin
        check("t4_ready_low", 64'(req_ready), 64'd0);
        @(negedge CLK_I);
        n++;
      end
    end
    req_valid = 2'b00;
    wait_idle(20);

    // Both requesters continuously valid: strict alternation starting from req 0.
    req_data  = 16'h55AA;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      push_rd();
      push_wr(3'd0, (k % 2 == 0) ? 32'hAA : 32'h55, (k % 2 == 0) ? 3'd0 : 3'd1);
    end
    for (int k = 0; k < 4; k++) wait_grant((k % 2 == 0) ? 2'b01 : 2'b10, 20);
    req_valid = 2'b00;
    wait_idle(20);

    // Reset while polling with a byte captured: the byte must never be written.
    lsr_limit = lsr_reads + 100000;
    req_data  = 16'h00C3;
    req_valid = 2'b01;
    push_rd();
    push_rd();
    wait_grant(2'b01, 10);
    req_valid = 2'b00;
    @(negedge CLK_I);
    @(negedge CLK_I);
    RST_I = 1'b1;
    @(negedge CLK_I);
    check("t5_rst_out", 64'({STB_O, WE_O, busy_o, ADD_O, DAT_O}), 64'd0);
    lsr_limit = lsr_reads;
    push_wr(3'd2, 32'd325, 3'd0);
    push_wr(3'd3, 32'd5207, 3'd0);
    @(negedge CLK_I);
    RST_I = 1'b0;
    wait_idle(10);

    // Pointer restored by reset: req 0 wins. ACK low holds the poll unchanged.
    ack_en    = 1'b0;
    req_data  = 16'h2211;
    req_valid = 2'b11;
    push_rd();
    push_wr(3'd0, 32'h11, 3'd0);
    wait_grant(2'b01, 10);
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK_I);
      check("ack_low_hold", 64'({STB_O, WE_O, ADD_O, DAT_O, busy_o}), 64'({1'b1, 1'b0, 3'd1, 32'd0, 1'b1}));
    end
    @(posedge CLK_I);
    #1;
    ack_en = 1'b1;
    wait_idle(20);

`ifdef UART_SCHED_TIMEOUT_EN
    // LSR stuck busy: 8 polls, one-cycle error, byte dropped, next request served.
    lsr_limit = lsr_reads + 100000;
    req_data  = 16'h6600;
    req_valid = 2'b10;
    for (int i = 0; i < 8; i++) push_rd();
    wait_grant(2'b10, 10);
    req_valid = 2'b00;
    begin
      int n = 0;
      @(negedge CLK_I);
      while (!err_o && n < 40) begin
        @(negedge CLK_I);
        n++;
      end
    end
    check("to_err", 64'(err_o), 64'd1);
    check("to_idle", 64'({busy_o, STB_O}), 64'd0);
    @(negedge CLK_I);
    check("to_err_pulse", 64'(err_o), 64'd0);
    lsr_limit = lsr_reads;
    req_data  = 16'h0067;
    req_valid = 2'b01;
    push_rd();
    push_wr(3'd0, 32'h67, 3'd0);
    wait_grant(2'b01, 10);
    req_valid = 2'b00;
    wait_idle(20);
`endif

    repeat (2) @(negedge CLK_I);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
